// File: rtl/wb_load_arbiter.sv
// Writeback stage: arbitrates the register-file write port between ALU results and in-order load responses.
// Optional macro WB_BYPASS_EN forwards the draining load result to the decode source operands.
module wb_load_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           alu_we,
    input  logic [4:0]     alu_rd,
    input  logic [63:0]    alu_data,
    input  logic           ld_issue_valid,
    output logic           ld_issue_ready,
    input  logic [4:0]     ld_issue_rd,
    input  logic [2:0]     ld_issue_funct3,
    input  logic [2:0]     ld_issue_addr_lo,
    input  logic           ld_resp_valid,
    input  logic [63:0]    ld_resp_data,
    input  logic [4:0]     dec_rs1,
    input  logic [4:0]     dec_rs2,
    input  logic [4:0]     dec_rd,
    input  logic           dec_rd_we,
    output logic           hazard_stall,
`ifdef WB_BYPASS_EN
    output logic           byp_r1_valid,
    output logic           byp_r2_valid,
    output logic [63:0]    byp_r1_data,
    output logic [63:0]    byp_r2_data,
`endif
    output logic           rf_we,
    output logic [4:0]     rf_addr_w,
    output logic [63:0]    rf_data_w,
    output logic [PTR_W:0] pending_cnt
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic             valid_q [DEPTH];
    logic             done_q  [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [2:0]       f3_q    [DEPTH];
    logic [2:0]       lo_q    [DEPTH];
    logic [63:0]      data_q  [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, resp_q, resp_d, tail_q, tail_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_issue, do_resp, do_pop, head_drain;
    logic             byp1, byp2;

    function automatic logic [63:0] ld_extend(input logic [2:0] f3, input logic [2:0] lo,
                                              input logic [63:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        logic [63:0] r;
        // Lane index drops address bits below natural alignment.
        b = raw[{lo, 3'b000} +: 8];
        h = raw[{lo[2:1], 4'b0000} +: 16];
        w = raw[{lo[2], 5'b00000} +: 32];
        case (f3)
            3'b000:  r = {{56{b[7]}}, b};
            3'b001:  r = {{48{h[15]}}, h};
            3'b010:  r = {{32{w[31]}}, w};
            3'b011:  r = raw;
            3'b100:  r = {56'd0, b};
            3'b101:  r = {48'd0, h};
            3'b110:  r = {32'd0, w};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        ld_issue_ready = (cnt_q != FULL_CNT);
        do_issue       = ld_issue_valid && ld_issue_ready;
        do_resp        = ld_resp_valid && valid_q[resp_q] && !done_q[resp_q];
        head_drain     = valid_q[head_q] && done_q[head_q];
        do_pop         = head_drain && !alu_we;

        head_d = head_q + PTR_W'(do_pop);
        resp_d = resp_q + PTR_W'(do_resp);
        tail_d = tail_q + PTR_W'(do_issue);
        cnt_d  = cnt_q + (PTR_W+1)'(do_issue) - (PTR_W+1)'(do_pop);

        rf_we     = 1'b0;
        rf_addr_w = '0;
        rf_data_w = '0;
        if (alu_we) begin
            rf_we     = (alu_rd != 5'd0);
            rf_addr_w = alu_rd;
            rf_data_w = alu_data;
        end else if (head_drain) begin
            rf_we     = (rd_q[head_q] != 5'd0);
            rf_addr_w = rd_q[head_q];
            rf_data_w = data_q[head_q];
        end
        if (reset) rf_we = 1'b0;

        byp1 = 1'b0;
        byp2 = 1'b0;
`ifdef WB_BYPASS_EN
        byp1 = do_pop && rf_we && (rf_addr_w == dec_rs1);
        byp2 = do_pop && rf_we && (rf_addr_w == dec_rs2);
`endif

        // A forwarded head no longer blocks the source it feeds.
        hazard_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rd_q[i] != 5'd0) begin
                if (rd_q[i] == dec_rs1 && !(byp1 && PTR_W'(i) == head_q)) hazard_stall = 1'b1;
                if (rd_q[i] == dec_rs2 && !(byp2 && PTR_W'(i) == head_q)) hazard_stall = 1'b1;
                if (dec_rd_we && rd_q[i] == dec_rd) hazard_stall = 1'b1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_r1_valid = byp1;
    assign byp_r2_valid = byp2;
    assign byp_r1_data  = rf_data_w;
    assign byp_r2_data  = rf_data_w;
`endif

    assign pending_cnt = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            resp_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
                rd_q[i]    <= '0;
                f3_q[i]    <= '0;
                lo_q[i]    <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            head_q <= head_d;
            resp_q <= resp_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (do_issue) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                rd_q[tail_q]    <= ld_issue_rd;
                f3_q[tail_q]    <= ld_issue_funct3;
                lo_q[tail_q]    <= ld_issue_addr_lo;
            end
            if (do_resp) begin
                done_q[resp_q] <= 1'b1;
                data_q[resp_q] <= ld_extend(f3_q[resp_q], lo_q[resp_q], ld_resp_data);
            end
            if (do_pop) valid_q[head_q] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_load_arbiter.sv
// Randomized and directed bench for wb_load_arbiter against a queue-based reference model.
module tb_wb_load_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        ld_issue_valid;
    logic        ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic [2:0]  ld_issue_funct3;
    logic [2:0]  ld_issue_addr_lo;
    logic        ld_resp_valid;
    logic [63:0] ld_resp_data;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rd_we;
    logic        hazard_stall;
    logic        rf_we;
    logic [4:0]  rf_addr_w;
    logic [63:0] rf_data_w;
    logic [2:0]  pending_cnt;
`ifdef WB_BYPASS_EN
    logic        byp_r1_valid, byp_r2_valid;
    logic [63:0] byp_r1_data, byp_r2_data;
`endif

    wb_load_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
        .ld_issue_rd(ld_issue_rd), .ld_issue_funct3(ld_issue_funct3),
        .ld_issue_addr_lo(ld_issue_addr_lo),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
        .hazard_stall(hazard_stall),
`ifdef WB_BYPASS_EN
        .byp_r1_valid(byp_r1_valid), .byp_r2_valid(byp_r2_valid),
        .byp_r1_data(byp_r1_data), .byp_r2_data(byp_r2_data),
`endif
        .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [2:0]  lo;
        bit          done;
        logic [63:0] data;
    } ld_t;

    ld_t q[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load extension from access size and signedness, using shifts and masks.
    function automatic logic [63:0] model_ext(input logic [2:0] f3, input logic [2:0] lo,
                                              input logic [63:0] raw);
        int          nbytes;
        int          off;
        logic [63:0] v, m;
        if (f3 == 3'b111) return 64'd0;
        case (f3[1:0])
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 4;
            default: nbytes = 8;
        endcase
        off = (int'(lo) / nbytes) * nbytes;
        v   = raw >> (off * 8);
        if (nbytes < 8) begin
            m = (64'd1 << (nbytes * 8)) - 64'd1;
            v = v & m;
            if (!f3[2] && v[nbytes*8-1]) v = v | ~m;
        end
        return v;
    endfunction

    task automatic check_outputs();
        logic        drain, ew, st, b1, b2;
        logic [4:0]  ea;
        logic [63:0] ed;
        drain = !alu_we && q.size() > 0 && q[0].done;
        ew = 1'b0; ea = '0; ed = '0;
        if (alu_we) begin
            ew = (alu_rd != 0); ea = alu_rd; ed = alu_data;
        end else if (drain) begin
            ew = (q[0].rd != 0); ea = q[0].rd; ed = q[0].data;
        end
        if (reset) ew = 1'b0;
        b1 = 1'b0;
        b2 = 1'b0;
`ifdef WB_BYPASS_EN
        b1 = drain && !reset && q[0].rd != 0 && q[0].rd == dec_rs1;
        b2 = drain && !reset && q[0].rd != 0 && q[0].rd == dec_rs2;
`endif
        st = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].rd != 0) begin
                if (q[i].rd == dec_rs1 && !(i == 0 && b1)) st = 1'b1;
                if (q[i].rd == dec_rs2 && !(i == 0 && b2)) st = 1'b1;
                if (dec_rd_we && q[i].rd == dec_rd) st = 1'b1;
            end
        end
        check_val("rf_we", rf_we, ew);
        check_val("rf_addr_w", rf_addr_w, ea);
        check_val("rf_data_w", rf_data_w, ed);
        check_val("hazard_stall", hazard_stall, st);
        check_val("ld_issue_ready", ld_issue_ready, q.size() < DEPTH);
        check_val("pending_cnt", pending_cnt, q.size());
`ifdef WB_BYPASS_EN
        check_val("byp_r1_valid", byp_r1_valid, b1);
        check_val("byp_r2_valid", byp_r2_valid, b2);
        if (b1) check_val("byp_r1_data", byp_r1_data, ed);
        if (b2) check_val("byp_r2_data", byp_r2_data, ed);
`endif
    endtask

    task automatic model_update();
        logic drain, accept, found;
        ld_t  e;
        if (reset) begin
            q.delete();
            return;
        end
        drain  = !alu_we && q.size() > 0 && q[0].done;
        accept = ld_issue_valid && q.size() < DEPTH;
        found  = 1'b0;
        if (ld_resp_valid) begin
            for (int i = 0; i < q.size(); i++) begin
                if (!found && !q[i].done) begin
                    q[i].done = 1'b1;
                    q[i].data = model_ext(q[i].f3, q[i].lo, ld_resp_data);
                    found = 1'b1;
                end
            end
        end
        if (drain) void'(q.pop_front());
        if (accept) begin
            e.rd = ld_issue_rd; e.f3 = ld_issue_funct3; e.lo = ld_issue_addr_lo;
            e.done = 1'b0; e.data = '0;
            q.push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        alu_we = 0; alu_rd = 0; alu_data = 0;
        ld_issue_valid = 0; ld_issue_rd = 0; ld_issue_funct3 = 0; ld_issue_addr_lo = 0;
        ld_resp_valid = 0; ld_resp_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_rd_we = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] lo);
        ld_issue_valid = 1; ld_issue_rd = rd; ld_issue_funct3 = f3; ld_issue_addr_lo = lo;
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        q.delete();
        #2;
        check_val("rst_ready", ld_issue_ready, 64'd1);
        check_val("rst_cnt", pending_cnt, 64'd0);
        check_val("rst_stall", hazard_stall, 64'd0);
        check_val("rst_we", rf_we, 64'd0);

        // LB / LBU from byte lane 3
        clear_inputs(); issue(5, 3'b000, 3); cycle();
        clear_inputs(); ld_resp_valid = 1; ld_resp_data = 64'h0000_0000_8000_0000; cycle();
        clear_inputs(); #2;
        check_val("lb_we", rf_we, 64'd1);
        check_val("lb_addr", rf_addr_w, 64'd5);
        check_val("lb_data", rf_data_w, 64'hFFFF_FFFF_FFFF_FF80);
        cycle();
        clear_inputs(); issue(5, 3'b100, 3); cycle();
        clear_inputs(); ld_resp_valid = 1; ld_resp_data = 64'h0000_0000_8000_0000; cycle();
        clear_inputs(); #2;
        check_val("lbu_data", rf_data_w, 64'h0000_0000_0000_0080);
        cycle();

        // ALU beats a completed load
        clear_inputs(); issue(3, 3'b010, 4); cycle();
        clear_inputs(); ld_resp_valid = 1; ld_resp_data = 64'h1234_5678_9ABC_DEF0; cycle();
        clear_inputs(); alu_we = 1; alu_rd = 7; alu_data = 64'd42; #2;
        check_val("alu_pri_addr", rf_addr_w, 64'd7);
        check_val("alu_pri_data", rf_data_w, 64'd42);
        cycle();
        clear_inputs(); #2;
        check_val("ld_after_alu_addr", rf_addr_w, 64'd3);
        check_val("ld_after_alu_data", rf_data_w, 64'h0000_0000_1234_5678);
        cycle();

        // Fill, ignored extra issue, pop does not free space in the same cycle
        for (int r = 1; r <= 4; r++) begin
            clear_inputs(); issue(5'(r), 3'b011, 0); cycle();
        end
        clear_inputs(); issue(6, 3'b011, 0); #2;
        check_val("full_ready", ld_issue_ready, 64'd0);
        cycle();
        clear_inputs(); ld_resp_valid = 1; ld_resp_data = 64'hA5; #2;
        check_val("full_cnt", pending_cnt, 64'd4);
        cycle();
        clear_inputs(); issue(6, 3'b011, 0); #2;
        check_val("pop_cycle_ready", ld_issue_ready, 64'd0);
        cycle();
        clear_inputs(); #2;
        check_val("after_pop_ready", ld_issue_ready, 64'd1);
        check_val("after_pop_cnt", pending_cnt, 64'd3);
        for (int k = 0; k < 3; k++) begin
            clear_inputs(); ld_resp_valid = 1; ld_resp_data = {$urandom, $urandom}; cycle();
        end
        repeat (4) begin clear_inputs(); cycle(); end

        // Load-use hazard on x9, then an rd=0 load
        clear_inputs(); issue(9, 3'b011, 0); dec_rs2 = 9; cycle();
        clear_inputs(); dec_rs2 = 9; #2;
        check_val("haz_pending", hazard_stall, 64'd1);
        ld_resp_valid = 1; ld_resp_data = 64'h99;
        cycle();
        clear_inputs(); dec_rs2 = 9; #2;
        check_val("haz_write_we", rf_we, 64'd1);
`ifndef WB_BYPASS_EN
        check_val("haz_write_stall", hazard_stall, 64'd1);
`endif
        cycle();
        clear_inputs(); dec_rs2 = 9; #2;
        check_val("haz_cleared", hazard_stall, 64'd0);
        cycle();
        clear_inputs(); issue(0, 3'b011, 0); cycle();
        clear_inputs(); #2;
        check_val("rd0_stall", hazard_stall, 64'd0);
        ld_resp_valid = 1; ld_resp_data = 64'h5;
        cycle();
        clear_inputs(); #2;
        check_val("rd0_we", rf_we, 64'd0);
        cycle();

`ifdef WB_BYPASS_EN
        clear_inputs(); issue(12, 3'b011, 0); cycle();
        clear_inputs(); ld_resp_valid = 1; ld_resp_data = 64'hC0DE; cycle();
        clear_inputs(); dec_rs1 = 12; #2;
        check_val("byp_valid", byp_r1_valid, 64'd1);
        check_val("byp_data", byp_r1_data, 64'hC0DE);
        check_val("byp_stall", hazard_stall, 64'd0);
        cycle();
`endif

        // Reset with three loads pending
        for (int r = 10; r <= 12; r++) begin
            clear_inputs(); issue(5'(r), 3'b011, 0); cycle();
        end
        clear_inputs(); ld_resp_valid = 1; ld_resp_data = 64'h77; cycle();
        clear_inputs(); alu_we = 1; alu_rd = 5; dec_rs1 = 11; reset = 1; #2;
        q.delete();
        check_val("midrst_cnt", pending_cnt, 64'd0);
        check_val("midrst_we", rf_we, 64'd0);
        check_val("midrst_stall", hazard_stall, 64'd0);
        check_val("midrst_ready", ld_issue_ready, 64'd1);
        cycle();
        reset = 0;
        clear_inputs(); ld_resp_valid = 1; ld_resp_data = 64'h88; cycle();
        clear_inputs(); #2;
        check_val("drop_we", rf_we, 64'd0);
        check_val("drop_cnt", pending_cnt, 64'd0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            alu_we           = ($urandom_range(0, 9) < 3);
            alu_rd           = 5'($urandom_range(0, 7));
            alu_data         = {$urandom, $urandom};
            ld_issue_valid   = 1'($urandom_range(0, 1));
            ld_issue_rd      = 5'($urandom_range(0, 7));
            ld_issue_funct3  = 3'($urandom_range(0, 7));
            ld_issue_addr_lo = 3'($urandom_range(0, 7));
            ld_resp_valid    = ($urandom_range(0, 9) < 4);
            ld_resp_data     = {$urandom, $urandom};
            dec_rs1          = 5'($urandom_range(0, 7));
            dec_rs2          = 5'($urandom_range(0, 7));
            dec_rd           = 5'($urandom_range(0, 7));
            dec_rd_we        = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
